shift_register_ctrl: RTL and testbench

Command-driven sequencer for the 8-bit shift register. It accepts one word per command over a valid/ready handshake and drives the register's load, shift, direction and serial-input controls. It performs a programmed number of left or right shifts, streams each bit shifted out, and returns the final register contents. It sits between a command source (host FSM or bus slave) and one shift-register instance, and owns all of that instance's control inputs except reset.

---
 rtl/shift_register_ctrl.sv | 114 +++++++++++
 tb/tb_shift_register_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/shift_register_ctrl.sv
// Command sequencer for an 8-bit shift register: load, N shifts (clamped to 8), stream out bits, return result.
// Optional rotate support is compiled in with `define SHIFT_CTRL_ROTATE_EN.
module shift_register_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [7:0] CMD_DATA,
  input  logic       CMD_DIR,
  input  logic [3:0] CMD_COUNT,
  input  logic       CMD_FILL,
  input  logic       CMD_ROT,
  output logic       SR_LOAD,
  output logic       SR_SHIFT,
  output logic       SR_DIR,
  output logic       SR_SER_IN,
  output logic [7:0] SR_DATA,
  input  logic [7:0] SR_Q,
  output logic       BIT_OUT,
  output logic       BIT_VALID,
  output logic [7:0] RESULT,
  output logic       DONE
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FINISH} state_t;

  state_t     state, next_state;
  logic [7:0] data_q;
  logic       dir_q;
  logic       fill_q;
  logic [3:0] count_q;
  logic       out_bit;
  logic       ser_bit;
  logic       accept;

  assign accept  = (state == IDLE) && CMD_VALID;
  assign out_bit = dir_q ? SR_Q[7] : SR_Q[0];

`ifdef SHIFT_CTRL_ROTATE_EN
  logic rot_q;

  always_ff @(posedge CLK) begin
    if (RST)         rot_q <= 1'b0;
    else if (accept) rot_q <= CMD_ROT;
  end

  // Rotation feeds the outgoing bit straight back in during the same cycle.
  assign ser_bit = rot_q ? out_bit : fill_q;
`else
  logic unused_rot;
  assign unused_rot = CMD_ROT;
  assign ser_bit    = fill_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      data_q    <= 8'h00;
      dir_q     <= 1'b0;
      fill_q    <= 1'b0;
      count_q   <= 4'd0;
      BIT_OUT   <= 1'b0;
      BIT_VALID <= 1'b0;
      RESULT    <= 8'h00;
      DONE      <= 1'b0;
    end else begin
      state     <= next_state;
      BIT_VALID <= (state == SHIFT);
      DONE      <= (state == FINISH);
      if (accept) begin
        data_q  <= CMD_DATA;
        dir_q   <= CMD_DIR;
        fill_q  <= CMD_FILL;
        count_q <= (CMD_COUNT > 4'd8) ? 4'd8 : CMD_COUNT;
      end
      if (state == SHIFT) begin
        BIT_OUT <= out_bit;
        count_q <= count_q - 4'd1;
      end
      if (state == FINISH) RESULT <= SR_Q;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    CMD_READY  = 1'b0;
    SR_LOAD    = 1'b0;
    SR_SHIFT   = 1'b0;
    SR_SER_IN  = 1'b0;
    unique case (state)
      IDLE: begin
        CMD_READY = !RST;
        if (CMD_VALID) next_state = LOAD;
      end
      LOAD: begin
        SR_LOAD    = 1'b1;
        next_state = (count_q == 4'd0) ? FINISH : SHIFT;
      end
      SHIFT: begin
        SR_SHIFT  = 1'b1;
        SR_SER_IN = ser_bit;
        if (count_q == 4'd1) next_state = FINISH;
      end
      FINISH: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign SR_DIR  = dir_q;
  assign SR_DATA = data_q;

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Directed bench for shift_register_ctrl: a behavioural 8-bit shift register closes the loop,
// and each command is checked for timing, streamed bits and result.
module tb_shift_register_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [7:0] CMD_DATA;
  logic       CMD_DIR;
  logic [3:0] CMD_COUNT;
  logic       CMD_FILL;
  logic       CMD_ROT;
  logic       SR_LOAD, SR_SHIFT, SR_DIR, SR_SER_IN;
  logic [7:0] SR_DATA;
  logic [7:0] SR_Q;
  logic       BIT_OUT, BIT_VALID, DONE;
  logic [7:0] RESULT;

  int errors = 0;
  int checks = 0;

  shift_register_ctrl dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_DATA(CMD_DATA),
    .CMD_DIR(CMD_DIR), .CMD_COUNT(CMD_COUNT), .CMD_FILL(CMD_FILL), .CMD_ROT(CMD_ROT),
    .SR_LOAD(SR_LOAD), .SR_SHIFT(SR_SHIFT), .SR_DIR(SR_DIR), .SR_SER_IN(SR_SER_IN),
    .SR_DATA(SR_DATA), .SR_Q(SR_Q),
    .BIT_OUT(BIT_OUT), .BIT_VALID(BIT_VALID), .RESULT(RESULT), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // The shift register the controller drives.
  always @(posedge CLK) begin
    if (SR_LOAD)       SR_Q <= SR_DATA;
    else if (SR_SHIFT) SR_Q <= SR_DIR ? {SR_Q[6:0], SR_SER_IN} : {SR_SER_IN, SR_Q[7:1]};
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive_cmd(input logic [7:0] data, input logic dir, input logic [3:0] count,
                           input logic fill, input logic rot);
    CMD_DATA  = data;
    CMD_DIR   = dir;
    CMD_COUNT = count;
    CMD_FILL  = fill;
    CMD_ROT   = rot;
    CMD_VALID = 1'b1;
  endtask

  // Called just after a falling edge; returns #1 after the accepting rising edge.
  task automatic wait_accept(input string tag, output int waited);
    logic ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      if (CMD_READY) begin
        @(posedge CLK);
        #1;
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
      waited++;
    end
    check({tag, "_accept"}, ok, 1'b1);
  endtask

  // Watches cycles 1.. after acceptance until DONE; n is the clamped shift count.
  task automatic run_check(input string tag, input int n, input logic [7:0] res_exp,
                           input logic [7:0] bits_exp);
    int loads = 0, shifts = 0, overlap = 0, nbits = 0, done_k = 0, first_bv = 0, busy_ready = 0;
    logic [7:0] bits = 8'h00;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (SR_LOAD)  loads++;
      if (SR_SHIFT) shifts++;
      if (SR_LOAD && SR_SHIFT) overlap++;
      if (BIT_VALID) begin
        if (nbits == 0) first_bv = k;
        bits = {bits[6:0], BIT_OUT};
        nbits++;
      end
      if (DONE) begin
        done_k = k;
        check({tag, "_ready_in_done"}, CMD_READY, 1'b1);
        check({tag, "_result"}, RESULT, res_exp);
        break;
      end else if (CMD_READY) begin
        busy_ready++;
      end
    end
    check({tag, "_done_cycle"}, done_k, n + 3);
    check({tag, "_loads"}, loads, 1);
    check({tag, "_shifts"}, shifts, n);
    check({tag, "_overlap"}, overlap, 0);
    check({tag, "_nbits"}, nbits, n);
    check({tag, "_bits"}, bits, bits_exp);
    check({tag, "_first_bv"}, first_bv, (n == 0) ? 0 : 3);
    check({tag, "_busy_ready"}, busy_ready, 0);
  endtask

  initial begin
    int waited;
    int bad_done, bad_bv;
    logic [7:0] rot_exp;
`ifdef SHIFT_CTRL_ROTATE_EN
    rot_exp = 8'h69;
`else
    rot_exp = 8'h09;
`endif
    RST = 1'b1;
    CMD_VALID = 1'b0;
    CMD_DATA = 8'h00; CMD_DIR = 1'b0; CMD_COUNT = 4'd0; CMD_FILL = 1'b0; CMD_ROT = 1'b0;
    SR_Q = 8'h00;
    repeat (2) @(negedge CLK);
    check("rst_ready", CMD_READY, 1'b0);
    check("rst_outs", {DONE, BIT_VALID, BIT_OUT, SR_LOAD, SR_SHIFT, SR_SER_IN, SR_DIR}, 7'd0);
    check("rst_result", RESULT, 8'h00);
    check("rst_sr_data", SR_DATA, 8'h00);
    RST = 1'b0;
    @(negedge CLK);
    check("rel_ready", CMD_READY, 1'b1);

    // Left 3 of 0xA5: bits 1,0,1, result 0x28.
    drive_cmd(8'hA5, 1'b1, 4'd3, 1'b0, 1'b0);
    wait_accept("c1", waited);
    CMD_VALID = 1'b0;
    run_check("c1", 3, 8'h28, 8'h05);

    // Right 8 of 0x81 with fill 1, then a held command accepted in the DONE cycle.
    @(negedge CLK);
    drive_cmd(8'h81, 1'b0, 4'd8, 1'b1, 1'b0);
    wait_accept("c2", waited);
    drive_cmd(8'h3C, 1'b0, 4'd0, 1'b0, 1'b0);
    run_check("c2", 8, 8'hFF, 8'h81);
    wait_accept("c3", waited);
    check("c3_back_to_back", waited, 0);
    CMD_VALID = 1'b0;
    run_check("c3", 0, 8'h3C, 8'h00);

    // Count 12 clamps to 8 shifts.
    @(negedge CLK);
    drive_cmd(8'h55, 1'b1, 4'd12, 1'b0, 1'b0);
    wait_accept("c4", waited);
    CMD_VALID = 1'b0;
    run_check("c4", 8, 8'h00, 8'h55);

    // Rotate request, right 4 of 0x96.
    @(negedge CLK);
    drive_cmd(8'h96, 1'b0, 4'd4, 1'b0, 1'b1);
    wait_accept("c5", waited);
    CMD_VALID = 1'b0;
    run_check("c5", 4, rot_exp, 8'h06);

    // Reset after the second shift of a count-6 command.
    @(negedge CLK);
    drive_cmd(8'hF0, 1'b1, 4'd6, 1'b0, 1'b0);
    wait_accept("c6", waited);
    CMD_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    check("c6_shifting", SR_SHIFT, 1'b1);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("c6_ready_in_rst", CMD_READY, 1'b0);
    @(negedge CLK);
    check("c6_shift_after_rst", SR_SHIFT, 1'b0);
    check("c6_result_after_rst", RESULT, 8'h00);
    check("c6_outs_after_rst", {DONE, BIT_VALID, BIT_OUT, SR_SER_IN, SR_DIR}, 5'd0);
    check("c6_ready_held", CMD_READY, 1'b0);
    RST = 1'b0;
    @(negedge CLK);
    check("c6_ready_after_rel", CMD_READY, 1'b1);
    bad_done = 0;
    bad_bv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (DONE) bad_done++;
      if (BIT_VALID || SR_SHIFT) bad_bv++;
    end
    check("c6_no_done", bad_done, 0);
    check("c6_no_shift", bad_bv, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
